clk_div_monitor: RTL
====================

CLK_DIV_MONITOR -- requirements
Module: clk_div_monitor

Interface
REQ-001 SHALL have parameter DIV_VAL_WIDTH, default 4: width of measured period/high-time fields.
REQ-002 SHALL have parameter LOCK_CNT, default 2: consecutive equal periods required to declare lock, range 1..15.
REQ-003 SHALL have port i_clk, input, 1, sole clock; all logic on rising edge.
REQ-004 SHALL have port i_reset, input, 1, reset; synchronous, active-low.
REQ-005 SHALL have port i_Enable, input, 1, measurement enable.
REQ-006 SHALL have port i_clk_div, input, 1, divided clock under test, treated as asynchronous data.
REQ-007 SHALL have port o_period, output, DIV_VAL_WIDTH, last measured period in i_clk cycles.
REQ-008 SHALL have port o_high_time, output, DIV_VAL_WIDTH, last measured high time in i_clk cycles.
REQ-009 SHALL have port o_valid, output, 1, one-cycle pulse when o_period/o_high_time update.
REQ-010 SHALL have port o_locked, output, 1, period stable for LOCK_CNT consecutive measurements.
REQ-011 SHALL have port o_overflow, output, 1, sticky flag: period exceeded 2^DIV_VAL_WIDTH-1.

Function
REQ-012 SHALL pass i_clk_div through a 2-flop synchronizer plus one history flop; rising edge = sync=1, history=0; falling edge = sync=0, history=1.
REQ-013 SHALL implement FSM states IDLE, ARM, MEASURE.
REQ-014 IDLE: counters cleared; go to ARM when i_Enable=1.
REQ-015 ARM: wait for first detected rising edge; on it, set period counter=1, high counter=1, go to MEASURE.
REQ-016 MEASURE: each cycle without rising edge, increment period counter; also increment high counter while synchronized level=1.
REQ-017 SHALL latch high counter on detected falling edge; a detected falling edge in the same cycle as a rising edge is impossible by construction.
REQ-018 On rising edge in MEASURE: o_period <= period counter, o_high_time <= latched high count, o_valid=1 next cycle only; counters restart at 1.
REQ-019 Measured value = exact count of i_clk rising edges between consecutive detected rising edges (divide-by-N input yields N).
REQ-020 Period counter reaching 2^DIV_VAL_WIDTH-1 without rising edge: set o_overflow, clear o_locked, return to ARM; no o_valid.
REQ-021 Match counter: increments when new period equals previous o_period, else reloads to 1; o_locked=1 when match counter >= LOCK_CNT; first measurement after ARM counts as 1.
REQ-022 Any period mismatch SHALL clear o_locked in the same cycle o_valid asserts.
REQ-023 i_Enable=0 in any state: go to IDLE next cycle, clear o_locked, hold o_period/o_high_time, no o_valid.
REQ-024 o_overflow SHALL clear only on reset or on i_Enable 0->1 transition.
REQ-025 Detection latency: o_valid asserts 4 i_clk cycles after the i_clk edge at which i_clk_div rises (2 sync + 1 edge + 1 register).

Reset
REQ-026 When i_reset=0 at a rising i_clk: FSM=IDLE, o_period=0, o_high_time=0, o_valid=0, o_locked=0, o_overflow=0, synchronizer and history flops=0, counters=0.
REQ-027 Reset mid-measurement SHALL discard partial counts; no o_valid in the reset cycle or the cycle following.
REQ-028 Reset SHALL be recognized only on i_clk edges; asynchronous assertion SHALL have no effect until next edge.

Verification
REQ-029 Divide-by-4, 50% duty, i_Enable=1 -> o_period=4, o_high_time=2, o_valid pulse every 4 cycles, o_locked=1 after 2nd valid.
REQ-030 Divide-by-3 (high 1, low 2) -> o_period=3, o_high_time=1, o_locked=1 after 2nd valid.
REQ-031 Ratio switches 4 -> 6 mid-run -> first valid at 6 clears o_locked; relocks after 2 consecutive 6s.
REQ-032 i_clk_div held constant 20 cycles, DIV_VAL_WIDTH=4 -> o_overflow=1 after 15 counted cycles, o_locked=0, no o_valid; toggle i_Enable -> o_overflow=0.
REQ-033 i_reset=0 one cycle during MEASURE -> all outputs 0 next cycle; first o_valid only after two rising edges post-reset.
REQ-034 i_Enable dropped while locked -> o_locked=0 next cycle, o_period held, o_valid never asserts while disabled.

Source files
------------

// File: rtl/clk_div_monitor.sv
// Divided-clock monitor: measures the period and high time of a slow
// clock in i_clk cycles, with lock detection and a sticky overflow flag.
module clk_div_monitor #(
  parameter int DIV_VAL_WIDTH = 4,
  parameter int LOCK_CNT      = 2
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_Enable,
  input  logic                     i_clk_div,
  output logic [DIV_VAL_WIDTH-1:0] o_period,
  output logic [DIV_VAL_WIDTH-1:0] o_high_time,
  output logic                     o_valid,
  output logic                     o_locked,
  output logic                     o_overflow
);

  localparam int W = DIV_VAL_WIDTH;
  localparam logic [W-1:0] CNT_MAX = '1;
  localparam logic [W-1:0] CNT_ONE = W'(1);
  localparam logic [3:0]   LOCK_TH = 4'(LOCK_CNT);

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    MEASURE
  } state_e;

  state_e         state_q;
  logic           sync1_q;
  logic           sync2_q;
  logic           hist_q;
  logic           rise_q;
  logic           fall_q;
  logic           en_q;
  logic [W-1:0]   per_cnt_q;
  logic [W-1:0]   high_cnt_q;
  logic [W-1:0]   high_lat_q;
  logic [W-1:0]   period_q;
  logic [W-1:0]   high_q;
  logic [3:0]     match_q;
  logic [3:0]     match_d;
  logic           locked_d;
  logic           first_q;
  logic           valid_q;
  logic           locked_q;
  logic           ovf_q;

  // Synchronize the divided clock and register its edge strobes.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      hist_q  <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      sync1_q <= i_clk_div;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
      rise_q  <= sync2_q & ~hist_q;
      fall_q  <= ~sync2_q & hist_q;
      en_q    <= i_Enable;
    end
  end

  // Next match count for the period that completes on this rise.
  always_comb begin
    match_d = 4'd1;
    if (!first_q && (per_cnt_q == period_q)) begin
      if (match_q != 4'hF) begin
        match_d = match_q + 4'd1;
      end else begin
        match_d = match_q;
      end
    end
    locked_d = (match_d >= LOCK_TH);
  end

  // Measurement FSM with registered results and status flags.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q    <= IDLE;
      per_cnt_q  <= '0;
      high_cnt_q <= '0;
      high_lat_q <= '0;
      period_q   <= '0;
      high_q     <= '0;
      match_q    <= 4'd0;
      first_q    <= 1'b0;
      valid_q    <= 1'b0;
      locked_q   <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (i_Enable && !en_q) begin
        ovf_q <= 1'b0;
      end
      if (!i_Enable) begin
        state_q    <= IDLE;
        locked_q   <= 1'b0;
        per_cnt_q  <= '0;
        high_cnt_q <= '0;
      end else begin
        unique case (state_q)
          IDLE: begin
            per_cnt_q  <= '0;
            high_cnt_q <= '0;
            high_lat_q <= '0;
            match_q    <= 4'd0;
            state_q    <= ARM;
          end
          ARM: begin
            if (rise_q) begin
              per_cnt_q  <= CNT_ONE;
              high_cnt_q <= CNT_ONE;
              first_q    <= 1'b1;
              state_q    <= MEASURE;
            end
          end
          MEASURE: begin
            if (rise_q) begin
              period_q   <= per_cnt_q;
              high_q     <= high_lat_q;
              valid_q    <= 1'b1;
              match_q    <= match_d;
              locked_q   <= locked_d;
              first_q    <= 1'b0;
              per_cnt_q  <= CNT_ONE;
              high_cnt_q <= CNT_ONE;
            end else if (per_cnt_q == CNT_MAX) begin
              // Period would not fit the output field.
              ovf_q      <= 1'b1;
              locked_q   <= 1'b0;
              per_cnt_q  <= '0;
              high_cnt_q <= '0;
              state_q    <= ARM;
            end else begin
              per_cnt_q <= per_cnt_q + CNT_ONE;
              if (hist_q && (high_cnt_q != CNT_MAX)) begin
                high_cnt_q <= high_cnt_q + CNT_ONE;
              end
              if (fall_q) begin
                high_lat_q <= high_cnt_q;
              end
            end
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign o_period    = period_q;
  assign o_high_time = high_q;
  assign o_valid     = valid_q;
  assign o_locked    = locked_q;
  assign o_overflow  = ovf_q;

endmodule
